// File: rtl/left_shift_serializer_pkg.sv
// Shared definitions for the shifting library serializers.
// Holds FSM state encodings and counter sizing.
package left_shift_serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/left_shift_register_base.sv
// Parallel-load left shift register with clear, zero fill.
// Load wins over clear, clear wins over shift.
module left_shift_register_base
    import left_shift_serializer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DEPTH-1:0] load_data,
    input  logic             enable,
    input  logic             clear,
    output logic [DEPTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= load_data;
        end else if (clear) begin
            out <= '0;
        end else if (enable) begin
            out <= {out[DEPTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/left_shift_serializer.sv
// MSB-first serializer with valid/ready load and enable strobe.
// Back-to-back words reload on the last-bit edge with no bubble.
module left_shift_serializer
    import left_shift_serializer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DEPTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enable,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [DEPTH-1:0] sreg;
    logic             accept;
    logic             last;
    logic             shift_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= last;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last       = 1'b0;
        load_ready = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                last       = (cnt == CNT_ONE) && enable;
                load_ready = last;
                if (enable && cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end
                if (last) begin
                    state_nxt = IDLE;
                end
            end
        endcase
        // A reload on the last-bit edge keeps the FSM in SHIFT
        accept = load_valid && load_ready;
        if (accept) begin
            state_nxt = SHIFT;
            cnt_nxt   = CNT_FULL;
        end
    end

    assign shift_en = (state == SHIFT) && enable;

    left_shift_register_base #(
        .DEPTH(DEPTH)
    ) u_sreg (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_data(data_in),
        .enable   (shift_en),
        .clear    (last),
        .out      (sreg)
    );

    assign busy = (state == SHIFT);
    assign out  = busy & sreg[DEPTH-1];

endmodule

// File: tb/tb_left_shift_serializer.sv
// Bench for left_shift_serializer: directed scenarios plus random
// traffic checked against a bit-queue reference model.
module tb_left_shift_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       enable;
    logic       load_ready;
    logic       out;
    logic       busy;
    logic       done;

    logic       reset2;
    logic [1:0] data_in2;
    logic       load_valid2;
    logic       enable2;
    logic       load_ready2;
    logic       out2;
    logic       busy2;
    logic       done2;

    int vecs = 0;
    int errs = 0;

    // Reference model: remaining bits of the word in flight, front on out
    bit   q[$];
    bit   m_done = 1'b0;
    bit   m_acc;
    bit   exp_ready;
    logic obs_ready;

    always #5 clk = ~clk;

    left_shift_serializer #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .enable    (enable),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    left_shift_serializer #(.DEPTH(2)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .data_in   (data_in2),
        .load_valid(load_valid2),
        .load_ready(load_ready2),
        .enable    (enable2),
        .out       (out2),
        .busy      (busy2),
        .done      (done2)
    );

    function automatic bit m_out();
        return (q.size() != 0) ? q[0] : 1'b0;
    endfunction

    task automatic tick(input logic r, input logic v,
                        input logic [7:0] d, input logic e);
        reset      = r;
        load_valid = v;
        data_in    = d;
        enable     = e;
        #2;
        obs_ready = load_ready;
        exp_ready = (q.size() == 0) || (q.size() == 1 && e);
        m_acc     = !r && v && exp_ready;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            m_done = (q.size() == 1) && e;
            if (e && q.size() != 0) void'(q.pop_front());
            if (m_acc) begin
                q.delete();
                for (int i = 7; i >= 0; i--) q.push_back(d[i]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 8'hAA, 1'b1);
            vecs++;
            if ({out, busy, done} !== 3'b000) begin
                errs++;
                $display("FAIL reset_outs[%0d]: got %b want 000", i,
                         {out, busy, done});
            end
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        vecs++;
        if (obs_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: got %b want 1", obs_ready);
        end
        vecs++;
        if ({out, busy, done} !== 3'b000) begin
            errs++;
            $display("FAIL reset_idle: got %b want 000", {out, busy, done});
        end
    endtask

    task automatic test_single();
        logic [7:0] pat;
        int busy_cnt;
        pat = 8'hA5;
        busy_cnt = 0;
        tick(1'b0, 1'b1, pat, 1'b1);
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (out !== pat[7-i] || done !== 1'b0) begin
                errs++;
                $display("FAIL single_bit[%0d]: got out=%b done=%b want out=%b done=0",
                         i, out, done, pat[7-i]);
            end
            if (busy === 1'b1) busy_cnt++;
            tick(1'b0, 1'b0, 8'h00, 1'b1);
        end
        vecs++;
        if (busy_cnt != 8) begin
            errs++;
            $display("FAIL single_busy_cycles: got %0d want 8", busy_cnt);
        end
        vecs++;
        if ({out, busy, done} !== 3'b001) begin
            errs++;
            $display("FAIL single_end: got %b want 001", {out, busy, done});
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        vecs++;
        if ({out, busy, done} !== 3'b000) begin
            errs++;
            $display("FAIL single_after: got %b want 000", {out, busy, done});
        end
    endtask

    task automatic test_stall();
        int en_cnt;
        tick(1'b0, 1'b1, 8'h80, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        en_cnt = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 8'h55, 1'b0);
            vecs++;
            if (obs_ready !== 1'b0 || out !== 1'b0 || busy !== 1'b1
                || done !== 1'b0) begin
                errs++;
                $display("FAIL stall[%0d]: got rdy=%b out=%b busy=%b done=%b want 0 0 1 0",
                         i, obs_ready, out, busy, done);
            end
        end
        while (en_cnt < 8) begin
            vecs++;
            if (done !== 1'b0) begin
                errs++;
                $display("FAIL stall_early_done[%0d]: got 1 want 0", en_cnt);
            end
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            en_cnt++;
        end
        vecs++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL stall_done: got done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        int acc_cnt;
        int dpos[$];
        bits = '0;
        acc_cnt = 0;
        tick(1'b0, 1'b1, 8'hFF, 1'b1);
        if (m_acc) acc_cnt++;
        for (int i = 0; i < 16; i++) begin
            bits[15-i] = out;
            vecs++;
            if (busy !== 1'b1) begin
                errs++;
                $display("FAIL b2b_busy[%0d]: got %b want 1", i, busy);
            end
            tick(1'b0, acc_cnt < 2, 8'h00, 1'b1);
            if (m_acc) acc_cnt++;
            if (done === 1'b1) dpos.push_back(i);
        end
        vecs++;
        if (bits !== 16'hFF00) begin
            errs++;
            $display("FAIL b2b_bits: got %h want ff00", bits);
        end
        vecs++;
        if (dpos.size() != 2 || dpos[1] - dpos[0] != 8) begin
            errs++;
            $display("FAIL b2b_done: got %0d pulses want 2 pulses 8 apart",
                     dpos.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pat;
        tick(1'b0, 1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        vecs++;
        if ({out, busy, done} !== 3'b000) begin
            errs++;
            $display("FAIL midreset: got %b want 000", {out, busy, done});
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        vecs++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL midreset_nodone: got %b want 0", done);
        end
        pat = 8'h3C;
        tick(1'b0, 1'b1, pat, 1'b1);
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (out !== pat[7-i]) begin
                errs++;
                $display("FAIL midreset_bit[%0d]: got %b want %b", i, out, pat[7-i]);
            end
            tick(1'b0, 1'b0, 8'h00, 1'b1);
        end
        vecs++;
        if (done !== 1'b1) begin
            errs++;
            $display("FAIL midreset_done: got %b want 1", done);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        d = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, d,
                 $urandom_range(0, 9) < 7);
            if (m_acc) d = 8'($urandom);
            vecs++;
            if (obs_ready !== exp_ready || out !== m_out()
                || busy !== (q.size() != 0) || done !== m_done) begin
                errs++;
                $display("FAIL rand[%0d]: got rdy=%b out=%b busy=%b done=%b want %b %b %b %b",
                         i, obs_ready, out, busy, done, exp_ready, m_out(),
                         q.size() != 0, m_done);
            end
        end
    endtask

    task automatic test_depth2();
        logic [2:0] got[3];
        reset2 = 1'b1;
        @(posedge clk);
        #1;
        reset2      = 1'b0;
        load_valid2 = 1'b1;
        data_in2    = 2'b10;
        enable2     = 1'b1;
        @(posedge clk);
        #1;
        load_valid2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got[i] = {out2, busy2, done2};
            @(posedge clk);
            #1;
        end
        vecs++;
        if (got[0] !== 3'b110 || got[1] !== 3'b010 || got[2] !== 3'b001) begin
            errs++;
            $display("FAIL depth2_seq: got %b %b %b want 110 010 001",
                     got[0], got[1], got[2]);
        end
        vecs++;
        if (dut2.cnt !== 2'd0 || done2 !== 1'b0 || out2 !== 1'b0) begin
            errs++;
            $display("FAIL depth2_stop: got cnt=%0d done=%b out=%b want 0 0 0",
                     dut2.cnt, done2, out2);
        end
        enable2 = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        data_in     = '0;
        load_valid  = 1'b0;
        enable      = 1'b0;
        reset2      = 1'b1;
        data_in2    = '0;
        load_valid2 = 1'b0;
        enable2     = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_depth2();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
